// File: rtl/uart_cmd_dispatcher.sv
// uart_cmd_dispatcher: buffers parsed UART commands and runs them one at a time on a register bus.
// Latency: in_ready edge seen at N, FIFO write at N+1, mst_req or rsp_valid high after N+2 when idle.
// Backpressure: response holds until rsp_ready; full FIFO drops the command and sets sticky overflow.
// Optional per-transaction timeout is compiled in with UART_DISPATCH_TIMEOUT_EN.

// uart_cmd_fifo: generic synchronous FIFO with occupancy count.
// Latency: pushed entry is visible at the head one cycle after the push.
// Backpressure: a push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_cmd_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push_vld,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop_rdy,
  output logic [WIDTH-1:0]       o_head_dat,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty    = (r_level == '0);
  assign o_full     = (r_level == (AW+1)'(DEPTH));
  assign o_level    = r_level;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_rd_en    = i_pop_rdy && !o_empty;
  assign w_wr_en    = i_push_vld && (!o_full || w_rd_en);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

module uart_cmd_dispatcher #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_ready,
  input  logic [31:0]            in_command,
  input  logic [31:0]            in_address,
  input  logic [31:0]            in_data,
  output logic                   mst_req,
  output logic                   mst_we,
  output logic [31:0]            mst_addr,
  output logic [31:0]            mst_wdata,
  input  logic                   mst_ack,
  input  logic [31:0]            mst_rdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_status,
  output logic [31:0]            rsp_address,
  output logic [31:0]            rsp_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);
  localparam logic [7:0] OP_PING     = 8'h00;
  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;
  localparam logic [7:0] STS_OK      = 8'h00;
  localparam logic [7:0] STS_BAD_OP  = 8'h01;
  localparam logic [7:0] STS_TIMEOUT = 8'h02;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_cmd_dispatcher: DEPTH must be a power of two in 2..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ACK, ST_RESPOND} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_in_ready_q;
  logic        r_push_vld;
  cmd_t        r_push_dat;
  cmd_t        w_head;
  logic        w_fifo_empty, w_fifo_full, w_pop, w_drop, w_tmo_hit;
  logic        r_overflow;
  logic        r_mst_req, r_mst_we;
  logic [31:0] r_mst_addr, r_mst_wdata;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_status;
  logic [31:0] r_rsp_address, r_rsp_data;
  logic        w_mst_req_nxt, w_mst_we_nxt, w_rsp_valid_nxt;
  logic [31:0] w_mst_addr_nxt, w_mst_wdata_nxt, w_rsp_address_nxt, w_rsp_data_nxt;
  logic [7:0]  w_rsp_status_nxt;
  logic        w_unused_cmd_hi;

  // Only the opcode byte of the command word carries meaning.
  assign w_unused_cmd_hi = ^in_command[31:8];

  // Edge detect and capture in one step so the parser need not hold its words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready_q <= 1'b0;
      r_push_vld   <= 1'b0;
      r_push_dat   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_in_ready_q <= in_ready;
      r_push_vld   <= in_ready && !r_in_ready_q;
      if (in_ready && !r_in_ready_q) r_push_dat <= {in_command[7:0], in_address, in_data};
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_drop = r_push_vld && w_fifo_full && !w_pop;

  uart_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (r_push_vld),
    .i_push_dat (r_push_dat),
    .i_pop_rdy  (w_pop),
    .o_head_dat (w_head),
    .o_empty    (w_fifo_empty),
    .o_full     (w_fifo_full),
    .o_level    (fifo_level)
  );

`ifdef UART_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Held at zero outside WAIT_ACK, so every entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_tmo_cnt <= '0;
    else if (r_state != ST_WAIT_ACK) r_tmo_cnt <= '0;
    else                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo_hit = (r_state == ST_WAIT_ACK) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pop             = 1'b0;
    w_mst_req_nxt     = r_mst_req;
    w_mst_we_nxt      = r_mst_we;
    w_mst_addr_nxt    = r_mst_addr;
    w_mst_wdata_nxt   = r_mst_wdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_status_nxt  = r_rsp_status;
    w_rsp_address_nxt = r_rsp_address;
    w_rsp_data_nxt    = r_rsp_data;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop             = 1'b1;
          w_rsp_address_nxt = w_head.addr;
          if (w_head.op == OP_WRITE || w_head.op == OP_READ) begin
            w_mst_req_nxt   = 1'b1;
            w_mst_we_nxt    = (w_head.op == OP_WRITE);
            w_mst_addr_nxt  = w_head.addr;
            w_mst_wdata_nxt = w_head.data;
            w_state_nxt     = ST_WAIT_ACK;
          end else begin
            w_rsp_valid_nxt  = 1'b1;
            w_rsp_status_nxt = (w_head.op == OP_PING) ? STS_OK : STS_BAD_OP;
            w_rsp_data_nxt   = (w_head.op == OP_PING) ? w_head.data : 32'h0;
            w_state_nxt      = ST_RESPOND;
          end
        end
      end
      ST_WAIT_ACK: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (mst_ack) begin
          w_mst_req_nxt    = 1'b0;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_status_nxt = STS_OK;
          w_rsp_data_nxt   = r_mst_we ? r_mst_wdata : mst_rdata;
          w_state_nxt      = ST_RESPOND;
        end else if (w_tmo_hit) begin
          w_mst_req_nxt    = 1'b0;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_status_nxt = STS_TIMEOUT;
          w_rsp_data_nxt   = 32'h0;
          w_state_nxt      = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mst_req     <= 1'b0;
      r_mst_we      <= 1'b0;
      r_mst_addr    <= '0;
      r_mst_wdata   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_status  <= '0;
      r_rsp_address <= '0;
      r_rsp_data    <= '0;
    end else begin
      r_mst_req     <= w_mst_req_nxt;
      r_mst_we      <= w_mst_we_nxt;
      r_mst_addr    <= w_mst_addr_nxt;
      r_mst_wdata   <= w_mst_wdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_status  <= w_rsp_status_nxt;
      r_rsp_address <= w_rsp_address_nxt;
      r_rsp_data    <= w_rsp_data_nxt;
    end
  end

  assign mst_req     = r_mst_req;
  assign mst_we      = r_mst_we;
  assign mst_addr    = r_mst_addr;
  assign mst_wdata   = r_mst_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_status  = r_rsp_status;
  assign rsp_address = r_rsp_address;
  assign rsp_data    = r_rsp_data;
  assign overflow    = r_overflow;
endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Scoreboard bench for uart_cmd_dispatcher: a bus responder and a response monitor check
// against expectations queued when each command is issued.
`timescale 1ns/1ps
module tb_uart_cmd_dispatcher;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_DISPATCH_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_ready = 1'b0;
  logic [31:0]   in_command = '0, in_address = '0, in_data = '0;
  logic          mst_req, mst_we;
  logic [31:0]   mst_addr, mst_wdata;
  logic          mst_ack = 1'b0;
  logic [31:0]   mst_rdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [7:0]    rsp_status;
  logic [31:0]   rsp_address, rsp_data;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  uart_cmd_dispatcher #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .in_command(in_command),
    .in_address(in_address), .in_data(in_data), .mst_req(mst_req), .mst_we(mst_we),
    .mst_addr(mst_addr), .mst_wdata(mst_wdata), .mst_ack(mst_ack), .mst_rdata(mst_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_address(rsp_address), .rsp_data(rsp_data), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
  } bus_t;

  typedef struct packed {
    logic [7:0]  st;
    logic [31:0] addr;
    logic [31:0] data;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_rsp = 0;
  bit   hold_ready = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a command yields a bus cycle for write/read and exactly one response.
  task automatic send(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input int dly, input logic [31:0] rdata, input bit accepted);
    bus_t b;
    rsp_t r;
    if (accepted) begin
      if (op == 8'h01 || op == 8'h02) begin
        b.we = (op == 8'h01); b.addr = addr; b.wdata = data; b.rdata = rdata; b.dly = dly;
        bus_q.push_back(b);
        if (TMO_ON && dly >= TMO) r = '{8'h02, addr, 32'h0};
        else                      r = '{8'h00, addr, (op == 8'h01) ? data : rdata};
      end else if (op == 8'h00) begin
        r = '{8'h00, addr, data};
      end else begin
        r = '{8'h01, addr, 32'h0};
      end
      rsp_q.push_back(r);
    end
    @(negedge clk);
    in_command = $urandom;
    in_command[7:0] = op;
    in_address = addr;
    in_data = data;
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    in_command = $urandom;
    in_address = $urandom;
    in_data = $urandom;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, 96'(rsp_q.size() + bus_q.size()), 96'd0);
    repeat (2) @(negedge clk);
  endtask

  // Bus responder: checks each request against the model, then acks after the queued delay.
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      mst_ack = 1'b0;
      if (mst_req) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexpected_req actual_addr=%h required=no request", mst_addr);
          b.we = mst_we; b.addr = mst_addr; b.wdata = mst_wdata; b.rdata = '0; b.dly = 0;
        end else begin
          b = bus_q.pop_front();
          chk("bus_cmd", {mst_we, mst_addr, b.we ? mst_wdata : 32'h0},
                         {b.we, b.addr, b.we ? b.wdata : 32'h0});
        end
        for (int j = 0; j <= b.dly; j++) begin
          if (!mst_req) break;
          if (j == b.dly) begin
            chk("bus_hold", {mst_we, mst_addr}, {b.we, b.addr});
            mst_ack = 1'b1;
            mst_rdata = b.rdata;
            @(negedge clk);
            mst_ack = 1'b0;
            mst_rdata = $urandom;
          end else begin
            @(negedge clk);
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mst_ack = 1'b1;
      end
    end
  end

  // Response monitor: drives rsp_ready and scores every completed handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=%h required=no response", {rsp_status, rsp_address, rsp_data});
        end else begin
          e = rsp_q.pop_front();
          chk("rsp", {rsp_status, rsp_address, rsp_data}, e);
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    logic [7:0] op;
    repeat (3) @(negedge clk);
    chk("reset_bus", {mst_req, mst_we, mst_addr, mst_wdata}, '0);
    chk("reset_rsp", {rsp_valid, rsp_status, rsp_address, rsp_data}, '0);
    chk("reset_fifo", {fifo_level, overflow}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", {mst_req, rsp_valid, fifo_level, overflow}, '0);

    send(8'h01, 32'h10, 32'hDEADBEEF, 2, $urandom, 1'b1);
    chk("lat_req_n1", 96'(mst_req), 96'd0);
    @(negedge clk);
    chk("lat_req_n2", 96'(mst_req), 96'd1);
    wait_drain("write", 100);

    send(8'h02, 32'h20, 32'h0, 1, 32'h12345678, 1'b1);
    wait_drain("read", 100);
    send(8'h00, 32'h30, 32'hA5A5A5A5, 0, 32'h0, 1'b1);
    send(8'h7F, 32'h40, $urandom, 0, 32'h0, 1'b1);
    wait_drain("ping_badop", 100);

    hold_ready = 1'b1;
    @(negedge clk);
    chk("ovf_clear", 96'(overflow), 96'd0);
    for (int i = 0; i < DEPTH + 2; i++) send(8'h00, 32'h100 + 32'(i), $urandom, 0, 32'h0, i < DEPTH + 1);
    chk("ovf_level", 96'(fifo_level), 96'(DEPTH));
    chk("ovf_flag", 96'(overflow), 96'd1);
    base = n_rsp;
    hold_ready = 1'b0;
    wait_drain("ovf", 300);
    chk("ovf_rsp_count", 96'(n_rsp - base), 96'(DEPTH + 1));
    chk("ovf_sticky", 96'(overflow), 96'd1);

`ifdef UART_DISPATCH_TIMEOUT_EN
    send(8'h02, 32'h50, 32'h0, 1000, $urandom, 1'b1);
    n = 0;
    @(negedge clk);
    while (mst_req && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", 96'(n), 96'(TMO));
    wait_drain("tmo", 200);
    send(8'h02, 32'h54, 32'h0, TMO - 1, 32'hCAFEF00D, 1'b1);
    wait_drain("tmo_ack_wins", 200);
`endif

    for (int i = 0; i < 60; i++) begin
      n = 0;
      while (rsp_q.size() >= DEPTH && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (rsp_q.size() >= DEPTH) begin
        checks++;
        failures++;
        $display("FAIL rand_space pending=%0d required<%0d", rsp_q.size(), DEPTH);
      end
      case ($urandom_range(0, 9))
        0, 1:    op = 8'h00;
        2, 3, 4: op = 8'h01;
        5, 6, 7: op = 8'h02;
        default: op = 8'($urandom_range(3, 255));
      endcase
      send(op, $urandom, $urandom, $urandom_range(0, 5), $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain("random", 2000);

    send(8'h02, 32'h60, 32'h0, 1000, 32'h0, 1'b1);
    send(8'h01, 32'h64, $urandom, 0, 32'h0, 1'b1);
    send(8'h00, 32'h68, $urandom, 0, 32'h0, 1'b1);
    chk("rst_pre_req", 96'(mst_req), 96'd1);
    chk("rst_pre_level", 96'(fifo_level), 96'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_req", 96'(mst_req), 96'd0);
    chk("rst_level", 96'(fifo_level), 96'd0);
    chk("rst_ovf", 96'(overflow), 96'd0);
    rsp_q.delete();
    bus_q.delete();
    base = n_rsp;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_rsp", 96'(n_rsp - base), 96'd0);
    chk("rst_idle", {mst_req, rsp_valid, fifo_level}, '0);

    send(8'h01, 32'h70, 32'h0BADCAFE, 1, 32'h0, 1'b1);
    wait_drain("post_reset", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
